ax65_ram_req_ctrl: RTL and testbench



---
 rtl/ax65_ram_req_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ax65_ram_req_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ax65_ram_req_ctrl.sv
// ax65_ram_req_ctrl: valid/ready request front-end for the AX65 byte-write RAM with a credit-protected read response FIFO.
// Optional feature: define AX65_RAM_REQ_REG_EN to register the RAM drive pins (adds one cycle of read latency).
module ax65_ram_req_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_BYTE    = 4,
  parameter int BIT_PER_BYTE = 8,
  parameter int FIFO_DEPTH   = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic                                i_req_write,
  input  logic [ADDR_WIDTH-1:0]               i_req_addr,
  input  logic [DATA_BYTE*BIT_PER_BYTE-1:0]   i_req_wdata,
  input  logic [DATA_BYTE-1:0]                i_req_bwe,
  output logic                                o_rsp_valid,
  input  logic                                i_rsp_ready,
  output logic [DATA_BYTE*BIT_PER_BYTE-1:0]   o_rsp_rdata,
  output logic                                o_ram_cs,
  output logic [DATA_BYTE-1:0]                o_ram_bwe,
  output logic [ADDR_WIDTH-1:0]               o_ram_addr,
  output logic [DATA_BYTE*BIT_PER_BYTE-1:0]   o_ram_din,
  input  logic [DATA_BYTE*BIT_PER_BYTE-1:0]   i_ram_dout,
  output logic                                o_busy
);

  localparam int DW = DATA_BYTE * BIT_PER_BYTE;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2) begin : g_depth_chk
    $error("ax65_ram_req_ctrl: FIFO_DEPTH must be at least 2");
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  logic          accept;
  logic          rd_accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic [1:0]    inflight;
  logic [CW:0]   used;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];

  // Credit check uses only registered occupancy so ready never depends on the request or a same-cycle pop.
  always_comb begin
    used        = (CW + 1)'(count_q) + (CW + 1)'(inflight);
    o_req_ready = used < DEPTH_C;
    accept      = i_req_valid & o_req_ready;
    rd_accept   = accept & ~i_req_write;
    issue       = accept & ~(i_req_write & (i_req_bwe == '0));
  end

`ifdef AX65_RAM_REQ_REG_EN
  if (FIFO_DEPTH < 4) begin : g_tput_chk
    $warning("ax65_ram_req_ctrl: FIFO_DEPTH < 4 limits read throughput with registered RAM drive");
  end

  logic [1:0]            infl_q, infl_d;
  logic                  ram_cs_q, ram_cs_d;
  logic [DATA_BYTE-1:0]  ram_bwe_q, ram_bwe_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]         ram_din_q, ram_din_d;

  // Stage 0 marks the cycle the registered cs reaches the RAM; stage 1 is when its data returns.
  always_comb begin
    infl_d     = {infl_q[0], rd_accept};
    ram_cs_d   = issue;
    ram_bwe_d  = (accept & i_req_write) ? i_req_bwe : '0;
    ram_addr_d = i_req_addr;
    ram_din_d  = i_req_wdata;
    inflight   = {1'b0, infl_q[0]} + {1'b0, infl_q[1]};
    push       = infl_q[1];
    o_ram_cs   = ram_cs_q;
    o_ram_bwe  = ram_bwe_q;
    o_ram_addr = ram_addr_q;
    o_ram_din  = ram_din_q;
  end

  // Registered RAM drive and two-stage read tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl_q     <= '0;
      ram_cs_q   <= 1'b0;
      ram_bwe_q  <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      infl_q     <= infl_d;
      ram_cs_q   <= ram_cs_d;
      ram_bwe_q  <= ram_bwe_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end
`else
  logic infl_q, infl_d;

  // Combinational RAM drive; a read accepted now returns data next cycle.
  always_comb begin
    infl_d     = rd_accept;
    inflight   = {1'b0, infl_q};
    push       = infl_q;
    o_ram_cs   = issue;
    o_ram_bwe  = (accept & i_req_write) ? i_req_bwe : '0;
    o_ram_addr = i_req_addr;
    o_ram_din  = i_req_wdata;
  end

  // Single-stage read tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) infl_q <= 1'b0;
    else          infl_q <= infl_d;
  end
`endif

  // FIFO bookkeeping; push is unconditional because credit reserved the slot at accept time.
  always_comb begin
    pop         = o_rsp_valid & i_rsp_ready;
    count_d     = count_q + CW'(push) - CW'(pop);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    o_rsp_valid = count_q != '0;
    o_rsp_rdata = mem_q[rd_ptr_q];
    o_busy      = (inflight != 2'd0) | (count_q != '0);
  end

  // FIFO occupancy and pointers; reset discards everything in flight or queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage captures RAM read data in the cycle after the RAM saw the read.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_ram_dout;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) push |-> (count_q < FULL_C))
    else $error("ax65_ram_req_ctrl: push into full response FIFO");

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) pop |-> (count_q != '0))
    else $error("ax65_ram_req_ctrl: pop from empty response FIFO");

endmodule

// File: tb/tb_ax65_ram_req_ctrl.sv
// tb_ax65_ram_req_ctrl: directed and random checks of ax65_ram_req_ctrl against a transaction-level model.
module tb_ax65_ram_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_bwe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        ram_cs;
  logic [3:0]  ram_bwe;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        busy;

  ax65_ram_req_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_bwe   (req_bwe),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_ram_cs    (ram_cs),
    .o_ram_bwe   (ram_bwe),
    .o_ram_addr  (ram_addr),
    .o_ram_din   (ram_din),
    .i_ram_dout  (ram_dout),
    .o_busy      (busy)
  );

  localparam int DEPTH = 3;
  localparam int LAT   = 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_bwe == 4'd0) ram_dout <= ram[ram_addr];
      else for (int b = 0; b < 4; b++) if (ram_bwe[b]) ram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outstanding = 0;
  logic [31:0] exp_data [$];
  int exp_cyc [$];
  logic last_acc = 1'b0;
  int acc_cyc = 0;
  int pop_cyc = 0;
  logic [31:0] pop_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic e_ready, e_valid, e_cs, acc, pp;
    logic [3:0] e_bwe;
    @(negedge clk);
    e_ready = outstanding < DEPTH;
    e_valid = exp_data.size() != 0 && cyc >= exp_cyc[0] + LAT;
    acc     = req_valid && e_ready;
    e_cs    = acc && !(req_write && req_bwe == 4'd0);
    e_bwe   = (acc && req_write) ? req_bwe : 4'd0;
    pp      = e_valid && rsp_ready;
    chk("ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("busy", busy, outstanding != 0);
    chk("ram_cs", ram_cs, e_cs);
    chk("ram_bwe", ram_bwe, e_bwe);
    if (e_cs) chk("ram_addr", ram_addr, req_addr);
    if (e_cs && req_write) chk("ram_din", ram_din, req_wdata);
    if (e_valid) chk("rsp_rdata", rsp_rdata, exp_data[0]);
    if (pp) begin
      pop_data = rsp_rdata;
      pop_cyc  = cyc;
    end
    @(posedge clk);
    if (pp) begin
      void'(exp_data.pop_front());
      void'(exp_cyc.pop_front());
      outstanding--;
    end
    if (acc) begin
      acc_cyc = cyc;
      if (!req_write) begin
        exp_data.push_back(ref_mem[req_addr]);
        exp_cyc.push_back(cyc);
        outstanding++;
      end else begin
        for (int b = 0; b < 4; b++) if (req_bwe[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
      end
    end
    last_acc = acc;
    cyc++;
    #1;
  endtask

  task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_bwe   = be;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    chk("send_accepted", last_acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (outstanding != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int start, idx, n;
    for (int i = 0; i < 32; i++) ram[i] = $urandom;
    ram[5] = 32'hDEADBEEF;
    ram[3] = 32'hAABBCCDD;
    for (int i = 0; i < 32; i++) ref_mem[i] = ram[i];
    ram_dout  = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_bwe   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("reset_ready", req_ready, 1'b1);

    send(1'b0, 5'h05, '0, '0);
    drain();
    chk("read05_data", pop_data, 32'hDEADBEEF);
    chk("read05_latency", pop_cyc - acc_cyc, LAT);

    send(1'b1, 5'h03, 32'h11223344, 4'b0101);
    send(1'b0, 5'h03, '0, '0);
    drain();
    chk("raw_data", pop_data, 32'hAA22CC44);

    send(1'b1, 5'h09, 32'h12345678, 4'b0000);
    tick();
    chk("noop_busy", busy, 1'b0);
    chk("noop_ram", ram[9], ref_mem[9]);

    rsp_ready = 1'b1;
    start = cyc;
    for (int a = 0; a < 8; a++) send(1'b0, 5'(a), '0, '0);
    chk("b2b_cycles", cyc - start, 8);
    drain();
    chk("b2b_last", pop_data, ram[7]);

    rsp_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_addr = 5'(idx);
      tick();
      if (last_acc) idx++;
    end
    chk("stall_accepts", idx, DEPTH);
    chk("stall_ready", req_ready, 1'b0);
    chk("stall_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    n = 0;
    while (idx < 8 && n < 60) begin
      req_addr = 5'(idx);
      tick();
      if (last_acc) idx++;
      n++;
    end
    req_valid = 1'b0;
    chk("stall_all_sent", idx, 8);
    drain();
    chk("stall_last", pop_data, ram[7]);

    rsp_ready = 1'b0;
    for (int a = 10; a < 13; a++) send(1'b0, 5'(a), '0, '0);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    exp_data.delete();
    exp_cyc.delete();
    outstanding = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (6) tick();

    last_acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!req_valid || last_acc) begin
        req_valid = $urandom_range(0, 3) != 0;
        req_write = $urandom_range(0, 1) == 1;
        req_addr  = 5'($urandom_range(0, 31));
        req_wdata = $urandom;
        req_bwe   = 4'($urandom_range(0, 15));
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    req_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
